// File: rtl/demux_2_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes and a 2-entry skid buffer.
// Words leave strictly in arrival order; a stalled head channel blocks every other channel.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no word stored, out_valid all zero
// ONE   | head register M holds the only word
// TWO   | M holds the head, skid register S the next; in_ready low
module demux_2_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_val,
    input  logic [1:0]            sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [DATA_WIDTH-1:0] m_data;
    logic [1:0]            m_sel;
    logic [DATA_WIDTH-1:0] s_data;
    logic [1:0]            s_sel;

    logic in_fire;
    logic out_fire;
    logic m_load_in;
    logic m_load_s;
    logic s_load;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = (state != EMPTY) & out_ready[m_sel];

    always_comb begin
        next_state = state;
        m_load_in  = 1'b0;
        m_load_s   = 1'b0;
        s_load     = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state = ONE;
                    m_load_in  = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_load_in = 1'b1;
                end else if (in_fire) begin
                    next_state = TWO;
                    s_load     = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the head can move
                if (out_fire) begin
                    next_state = ONE;
                    m_load_s   = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            m_data   <= '0;
            m_sel    <= 2'd0;
            s_data   <= '0;
            s_sel    <= 2'd0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != TWO);
            if (m_load_in) begin
                m_data <= in_val;
                m_sel  <= sel;
            end else if (m_load_s) begin
                m_data <= s_data;
                m_sel  <= s_sel;
            end
            if (s_load) begin
                s_data <= in_val;
                s_sel  <= sel;
            end
        end
    end

    assign out_val   = m_data;
    assign out_valid = (state != EMPTY) ? (4'b0001 << m_sel) : 4'b0000;

    always_comb begin
        occupancy = 2'd0;
        unique case (state)
            EMPTY:   occupancy = 2'd0;
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_demux_2_reg.sv
// Directed bench for demux_2_reg: reset, routing, streaming, skid backpressure,
// head-of-line blocking and asynchronous reset in the middle of operation.
module tb_demux_2_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_val;
    logic [1:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_val;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] occupancy;

    int total = 0;
    int bad   = 0;

    demux_2_reg #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_val    (in_val),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_val   (out_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] v, input logic [7:0] d,
                           input logic [1:0] occ, input logic rdy);
        chk({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, v});
        if (v != 4'b0000) chk({tag, ".out_val"}, {24'd0, out_val}, {24'd0, d});
        chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_val    = 8'hFF;
        sel       = 2'd0;
        out_ready = 4'b0000;

        // reset held across edges with in_valid asserted
        tick();
        tick();
        chk_out("rst", 4'b0000, 8'h00, 2'd0, 1'b0);
        chk("rst.out_val", {24'd0, out_val}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rel.in_ready_pre", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel.in_ready_post", {31'd0, in_ready}, 32'd1);

        // single routing
        in_val = 8'hA5; sel = 2'd2; in_valid = 1'b1; out_ready = 4'b0100;
        tick();
        in_valid = 1'b0;
        chk_out("single.load", 4'b0100, 8'hA5, 2'd1, 1'b1);
        tick();
        chk_out("single.drain", 4'b0000, 8'h00, 2'd0, 1'b1);
        chk("single.hold_val", {24'd0, out_val}, 32'h0000_00A5);

        // streaming at full rate
        out_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            in_val   = 8'h10 + 8'(i);
            sel      = 2'(i % 4);
            in_valid = 1'b1;
            tick();
            chk_out($sformatf("stream%0d", i), 4'b0001 << (i % 4), 8'h10 + 8'(i), 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk_out("stream.end", 4'b0000, 8'h00, 2'd0, 1'b1);

        // backpressure into the skid register
        out_ready = 4'b0000;
        in_val = 8'h33; sel = 2'd1; in_valid = 1'b1;
        tick();
        chk_out("skid.first", 4'b0010, 8'h33, 2'd1, 1'b1);
        in_val = 8'h44; sel = 2'd3;
        tick();
        in_valid = 1'b0;
        in_val = 8'hEE; sel = 2'd0;
        chk_out("skid.full", 4'b0010, 8'h33, 2'd2, 1'b0);
        tick();
        chk_out("skid.hold", 4'b0010, 8'h33, 2'd2, 1'b0);
        out_ready = 4'b0010;
        tick();
        chk_out("skid.pop", 4'b1000, 8'h44, 2'd1, 1'b1);
        out_ready = 4'b1000;
        tick();
        chk_out("skid.empty", 4'b0000, 8'h00, 2'd0, 1'b1);

        // head-of-line blocking: channel 0 stalled, others ready
        out_ready = 4'b1110;
        in_val = 8'h55; sel = 2'd0; in_valid = 1'b1;
        tick();
        in_val = 8'h66; sel = 2'd2;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("hol%0d", i), 4'b0001, 8'h55, 2'd2, 1'b0);
            tick();
        end
        chk_out("hol.still", 4'b0001, 8'h55, 2'd2, 1'b0);
        out_ready = 4'b1111;
        tick();
        chk_out("hol.release", 4'b0100, 8'h66, 2'd1, 1'b1);
        tick();
        chk_out("hol.empty", 4'b0000, 8'h00, 2'd0, 1'b1);

        // asynchronous reset while full
        out_ready = 4'b0000;
        in_val = 8'h77; sel = 2'd1; in_valid = 1'b1;
        tick();
        in_val = 8'h88; sel = 2'd2;
        tick();
        in_valid = 1'b0;
        chk_out("mid.full", 4'b0010, 8'h77, 2'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid.rst", 4'b0000, 8'h00, 2'd0, 1'b0);
        chk("mid.rst_val", {24'd0, out_val}, 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 4'b1111;
        tick();
        chk_out("mid.after1", 4'b0000, 8'h00, 2'd0, 1'b1);
        tick();
        chk_out("mid.after2", 4'b0000, 8'h00, 2'd0, 1'b1);
        in_val = 8'h99; sel = 2'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_out("mid.fresh", 4'b1000, 8'h99, 2'd1, 1'b1);
        tick();
        chk_out("mid.fresh_drain", 4'b0000, 8'h00, 2'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
